uart_tx: RTL and testbench

Serial transmit engine of the UART peripheral. It buffers bytes written by the processor through the UART register file, serialises them onto the `tx` line, and applies the frame format, enable bits and baud divisor held in the CTRL and BAUD registers. It drives the `tx_fifo_full` and `busy` status bits back to the register file.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_fifo.sv | 61 ++++++
 rtl/uart_tx.sv | 149 ++++++++++++++
 tb/tb_uart_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART package.
//   uart_tx_state_e : transmit FSM state encoding
//   UART_FIFO_DEPTH : default depth of the TX/RX FIFOs
package packages;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } uart_tx_state_e;

  localparam int UART_FIFO_DEPTH = 8;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO shared by the UART transmit and receive paths.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   push, wr_data     : write request and data (dropped when full)
//   pop               : read request (ignored when empty)
//   rd_data           : current head entry
//   full, empty       : occupancy flags derived from the registered count
//   count             : number of stored entries
module uart_fifo #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because the depth is a power of two.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx.sv
// UART serial transmitter.
// Ports:
//   clock, reset            : clock and synchronous active-high reset
//   tx_fifo_wr_en/_data     : byte push into the TX FIFO
//   parity_en, parity       : parity enable and type (0 even, 1 odd)
//   stop_bit                : 0 = one stop bit, 1 = two
//   uart_en, tx_en          : enables; both needed to start a new frame
//   baud_rate               : clock cycles per bit (0 and 1 both mean 1)
//   tx                      : registered serial output, idles high
//   tx_fifo_full/_empty     : FIFO status
//   busy                    : FSM active or FIFO non-empty
//   tx_done                 : one-cycle pulse in the last stop-bit cycle
module uart_tx
  import packages::*;
#(
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
  parameter int DATA_W     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tx_fifo_wr_en,
  input  logic [7:0]  tx_fifo_data,
  input  logic        parity_en,
  input  logic        parity,
  input  logic        stop_bit,
  input  logic        uart_en,
  input  logic        tx_en,
  input  logic [15:0] baud_rate,
  output logic        tx,
  output logic        tx_fifo_full,
  output logic        tx_fifo_empty,
  output logic        busy,
  output logic        tx_done
);

  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_e     state, state_n;
  logic [15:0]        baud_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               baud_tick;
  logic               pop;
  logic               tx_n;
  logic               done_n;
  logic [7:0]         fifo_rd;
  logic [CNT_W-1:0]   fifo_count;

  // Frame configuration captured at pop time so register writes mid-frame
  // cannot disturb the frame on the line.
  logic [DATA_W-1:0]  shift;
  logic               frame_par_en;
  logic               frame_par_bit;
  logic               frame_stop2;
  logic [15:0]        frame_n;

  // Divisors below 2 saturate to one cycle per bit.
  function automatic logic [15:0] bit_time(input logic [15:0] b);
    return (b < 16'd2) ? 16'd1 : b;
  endfunction

  uart_fifo #(
    .DATA_W     (8),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (tx_fifo_wr_en),
    .wr_data (tx_fifo_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (tx_fifo_full),
    .empty   (tx_fifo_empty),
    .count   (fifo_count)
  );

  assign baud_tick = (state != TX_IDLE) && (baud_cnt == frame_n - 16'd1);
  assign busy      = (state != TX_IDLE) || (fifo_count != '0);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    done_n  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (uart_en && tx_en && !tx_fifo_empty) begin
          pop     = 1'b1;
          state_n = TX_START;
        end
      end
      TX_START: begin
        tx_n = 1'b0;
        if (baud_tick) state_n = TX_DATA;
      end
      TX_DATA: begin
        tx_n = shift[0];
        if (baud_tick && bit_cnt == BIT_W'(DATA_W - 1))
          state_n = frame_par_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_n = frame_par_bit;
        if (baud_tick) state_n = TX_STOP;
      end
      TX_STOP: begin
        if (baud_tick && (!frame_stop2 || bit_cnt == BIT_W'(1))) begin
          state_n = TX_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  // tx and tx_done are registered copies of the FSM decode, so the line
  // lags the state register by one cycle (pop edge, then start bit).
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state   <= state_n;
      tx      <= tx_n;
      tx_done <= done_n;
      if (state == TX_IDLE || baud_tick) baud_cnt <= '0;
      else                               baud_cnt <= baud_cnt + 16'd1;
      // bit_cnt restarts on every state change; within DATA it indexes the
      // data bit, within STOP it indexes the stop bit.
      if (state_n != state) bit_cnt <= '0;
      else if (baud_tick)   bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (pop) begin
      shift         <= fifo_rd[DATA_W-1:0];
      frame_par_en  <= parity_en;
      frame_par_bit <= (^fifo_rd[DATA_W-1:0]) ^ parity;
      frame_stop2   <= stop_bit;
      frame_n       <= bit_time(baud_rate);
    end else if (state == TX_DATA && baud_tick) begin
      shift <= shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic        clock = 1'b0;
  logic        reset;
  logic        tx_fifo_wr_en;
  logic [7:0]  tx_fifo_data;
  logic        parity_en;
  logic        parity;
  logic        stop_bit;
  logic        uart_en;
  logic        tx_en;
  logic [15:0] baud_rate;
  logic        tx;
  logic        tx_fifo_full;
  logic        tx_fifo_empty;
  logic        busy;
  logic        tx_done;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  uart_tx #(
    .FIFO_DEPTH (8),
    .DATA_W     (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tx_fifo_wr_en (tx_fifo_wr_en),
    .tx_fifo_data  (tx_fifo_data),
    .parity_en     (parity_en),
    .parity        (parity),
    .stop_bit      (stop_bit),
    .uart_en       (uart_en),
    .tx_en         (tx_en),
    .baud_rate     (baud_rate),
    .tx            (tx),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_empty (tx_fifo_empty),
    .busy          (busy),
    .tx_done       (tx_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    tx_fifo_wr_en = 1'b1;
    tx_fifo_data  = d;
    tick();
    tx_fifo_wr_en = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, " start seen"}, 16'(tx), 16'd0);
  endtask

  // Called in the first start-bit cycle; bits[0] is the start bit.
  task automatic check_frame(input string tag, input logic [11:0] bits,
                             input int nbits, input int n);
    int len = nbits * n;
    for (int c = 0; c < len; c++) begin
      check($sformatf("%s tx c%0d", tag, c), 16'(tx), 16'(bits[c / n]));
      check($sformatf("%s tx_done c%0d", tag, c), 16'(tx_done), 16'(c == len - 1));
      tick();
    end
    check({tag, " idle after"}, 16'(tx), 16'd1);
  endtask

  initial begin
    reset         = 1'b1;
    tx_fifo_wr_en = 1'b0;
    tx_fifo_data  = 8'h00;
    parity_en     = 1'b0;
    parity        = 1'b0;
    stop_bit      = 1'b0;
    uart_en       = 1'b1;
    tx_en         = 1'b1;
    baud_rate     = 16'd4;
    tick();
    tick();
    check("reset tx", 16'(tx), 16'd1);
    check("reset full", 16'(tx_fifo_full), 16'd0);
    check("reset empty", 16'(tx_fifo_empty), 16'd1);
    check("reset busy", 16'(busy), 16'd0);
    check("reset tx_done", 16'(tx_done), 16'd0);
    reset = 1'b0;
    tick();

    // Basic frame, 0x55, N=4, push-to-start latency.
    push(8'h55);
    check("basic empty after push", 16'(tx_fifo_empty), 16'd0);
    check("basic busy after push", 16'(busy), 16'd1);
    check("basic tx after push", 16'(tx), 16'd1);
    tick();
    check("basic tx at pop edge", 16'(tx), 16'd1);
    check("basic empty after pop", 16'(tx_fifo_empty), 16'd1);
    tick();
    check_frame("basic", 12'b0010_1010_1010, 10, 4);
    check("basic busy after", 16'(busy), 16'd0);
    check("basic empty after", 16'(tx_fifo_empty), 16'd1);

    // Parity, 0x07, N=2: odd -> parity 0, even -> parity 1.
    baud_rate = 16'd2;
    parity_en = 1'b1;
    parity    = 1'b1;
    push(8'h07);
    wait_start("odd");
    check_frame("odd", 12'b0100_0000_1110, 11, 2);
    parity = 1'b0;
    push(8'h07);
    wait_start("even");
    check_frame("even", 12'b0110_0000_1110, 11, 2);

    // Two stop bits, minimum divisor, back-to-back frames.
    parity_en = 1'b0;
    stop_bit  = 1'b1;
    baud_rate = 16'd0;
    push(8'h3C);
    push(8'hC3);
    wait_start("stop2 a");
    check_frame("stop2 a", 12'b0110_0111_1000, 11, 1);
    tick();
    check_frame("stop2 b", 12'b0111_1000_0110, 11, 1);
    check("stop2 empty", 16'(tx_fifo_empty), 16'd1);
    check("stop2 busy", 16'(busy), 16'd0);

    // FIFO full: nine pushes while disabled, ninth is dropped.
    stop_bit  = 1'b0;
    baud_rate = 16'd1;
    tx_en     = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push(8'(i));
      if (i == 6) check("full after 7", 16'(tx_fifo_full), 16'd0);
      if (i == 7) check("full after 8", 16'(tx_fifo_full), 16'd1);
    end
    check("full after 9", 16'(tx_fifo_full), 16'd1);
    check("full tx idle", 16'(tx), 16'd1);
    tx_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      d = 8'(i);
      wait_start($sformatf("fifo %0d", i));
      check_frame($sformatf("fifo %0d", i), {2'b00, 1'b1, d, 1'b0}, 10, 1);
    end
    check("fifo drained empty", 16'(tx_fifo_empty), 16'd1);
    check("fifo drained full", 16'(tx_fifo_full), 16'd0);
    repeat (15) tick();
    check("no ninth frame tx", 16'(tx), 16'd1);
    check("no ninth frame busy", 16'(busy), 16'd0);

    // Reset during DATA bit 3 with one byte still queued.
    baud_rate = 16'd4;
    push(8'h5A);
    push(8'h77);
    wait_start("rst");
    repeat (17) tick();
    check("rst data bit3", 16'(tx), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst tx", 16'(tx), 16'd1);
    check("rst busy", 16'(busy), 16'd0);
    check("rst empty", 16'(tx_fifo_empty), 16'd1);
    check("rst tx_done", 16'(tx_done), 16'd0);
    push(8'hA5);
    wait_start("after rst");
    check_frame("after rst", 12'b0011_0100_1010, 10, 4);
    repeat (10) tick();
    check("after rst tx", 16'(tx), 16'd1);
    check("after rst empty", 16'(tx_fifo_empty), 16'd1);

    // Disable during START with two bytes queued; config changes mid-frame.
    baud_rate = 16'd2;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    wait_start("dis");
    tx_en     = 1'b0;
    baud_rate = 16'd7;
    parity_en = 1'b1;
    check_frame("dis 11", 12'b0010_0010_0010, 10, 2);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("dis hold tx %0d", i), 16'(tx), 16'd1);
      tick();
    end
    check("dis empty", 16'(tx_fifo_empty), 16'd0);
    check("dis busy", 16'(busy), 16'd1);
    baud_rate = 16'd2;
    parity_en = 1'b0;
    tx_en     = 1'b1;
    wait_start("dis 22");
    check_frame("dis 22", 12'b0010_0100_0100, 10, 2);
    tick();
    check_frame("dis 33", 12'b0010_0110_0110, 10, 2);
    check("dis final empty", 16'(tx_fifo_empty), 16'd1);
    check("dis final busy", 16'(busy), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
